bip_data_responder: RTL and testbench
=====================================

Name: bip_data_responder

Overview:
- Memory-side responder for the BIP2 core's data bus. It decodes the core's data address, write-data and write-strobe signals and returns read data.
- The lower address range maps to a word-addressed data RAM. The top window maps to memory-mapped I/O: an output port, a synchronized input port and a reload timer with a sticky flag.
- The block sits between the BIP2 core and the board pins and completes the core's data-memory interface.

Parameters:
- ADDRESS_WIDTH, 11, data address width; matches the core's operand/address width.
- DATA_WIDTH, 16, data word width.
- IO_BASE, 11'h7F0, first I/O address. RAM depth is IO_BASE words (0 to IO_BASE-1).

Ports:
- clock_in, input, 1, system clock; all state updates on the rising edge.
- reset_in, input, 1, synchronous, active-high reset.
- data_address_in, input, ADDRESS_WIDTH, word address from the core.
- data_in, input, DATA_WIDTH, write data from the core.
- data_wr_in, input, 1, write strobe; a write commits at the rising edge while it is high.
- data_out, output, DATA_WIDTH, read data to the core.
- port_in, input, DATA_WIDTH, external asynchronous input pins.
- port_out, output, DATA_WIDTH, registered output port.
- timer_flag_out, output, 1, level copy of the timer flag.

Behaviour:
- Reads are combinational: data_out is a function of data_address_in and the current state, with zero-cycle latency. This is required because the single-cycle core consumes read data in the same cycle.
- RAM region (addr < IO_BASE):
  - Asynchronous read.
  - Write at the clock edge when data_wr_in=1.
  - Read-during-write returns the old word until the edge.
  - RAM contents are not reset.
- I/O offsets from IO_BASE:
  - +0 PORT_OUT: read/write.
  - +1 PORT_IN: read-only.
  - +2 RELOAD: read/write.
  - +3 COUNT: read-only.
  - +4 CTRL: bit0 EN is read/write; bit1 FLAG is read, write-1-to-clear; other bits read 0.
  - Offsets +5 to +15 are unmapped: read 0, writes ignored. Writes to read-only registers are ignored.
- Reset (reset_in=1 at an edge): port_out, RELOAD, COUNT, EN, FLAG and both synchronizer stages all go to 0. timer_flag_out=0. data_out then reads per the address with these zeroed values.
- Reset mid-operation: asserting reset_in overrides any write or timer event in that cycle.
- PORT_IN path:
  - Two-flop synchronizer on port_in.
  - A pin change becomes readable after exactly 2 rising edges.
- Timer (counting is evaluated each edge with EN=1 and no reset):
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: COUNT loads RELOAD and FLAG sets to 1.
  - EN=0: COUNT holds.
  - Setting EN from 0 to 1 does not reload COUNT.
- Writing RELOAD loads both RELOAD and COUNT at the same edge. The load overrides a decrement or reload in that cycle.
- RELOAD=0 with EN=1: FLAG sets every cycle.
- Simultaneous FLAG set and a write-1-to-clear in the same cycle: the set wins, so FLAG stays 1.
- A CTRL write updates EN at the edge. The counting decision in that same edge uses the old EN.
- timer_flag_out equals FLAG at all times.
- All arithmetic is unsigned DATA_WIDTH. The decrement never underflows because zero triggers a reload instead.

Optional Feature:
- Macro: BIP_TIMER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 16) and an internal prescale counter.
  - The timer performs one count step only on cycles where the prescale counter wraps from PRESCALE-1 to 0.
  - The prescale counter runs only while EN=1, resets to 0 on reset, and clears to 0 on any RELOAD write.
- Undefined: the timer steps on every EN=1 cycle, and no prescale logic is present.

Decomposition:
- Package bip_io_pkg holds:
  - I/O offset constants: OFS_PORT_OUT, OFS_PORT_IN, OFS_RELOAD, OFS_COUNT, OFS_CTRL.
  - CTRL bit indices: CTRL_EN_BIT=0, CTRL_FLAG_BIT=1.
  - A region-select enum: REGION_RAM, REGION_IO.
- One sub-module, bip_timer, contains RELOAD, COUNT, EN, FLAG and the optional prescaler.
- The top level keeps the address decode, the RAM, the port registers and the synchronizer.

Test Plan:
- RAM: write 16'h1234 at addr 5, then read addr 5 → data_out=16'h1234. Reading addr 6 during the write cycle returns its old value.
- I/O window: write 16'hA5A5 to 0x7F0 → port_out=16'hA5A5 next cycle. Write to 0x7F1 → no change. Read 0x7F8 → 0.
- Synchronizer: port_in steps 0 to 16'h00FF → reading 0x7F1 gives 0 after 1 edge and 16'h00FF after 2 edges.
- Timer: write RELOAD=3, then CTRL=1 → COUNT reads 3,2,1,0,3 on successive edges. FLAG and timer_flag_out go to 1 at the 0→3 edge. Writing CTRL=16'h0003 → FLAG=0, EN=1.
- Flag race: RELOAD=0, EN=1, write CTRL=2 (clear, EN=0) → FLAG stays 1 because set wins and the old EN is used. Next cycle FLAG holds and COUNT holds.
- Reset mid-count: COUNT=2, EN=1, port_out=16'hA5A5, then reset_in for 1 cycle → COUNT=0, EN=0, FLAG=0, port_out=0. A RAM word written earlier still reads its old value.

Source files
------------

// File: rtl/bip_io_pkg.sv
// bip_io_pkg: shared constants for the BIP2 data-bus responder.
//   - I/O register offsets relative to IO_BASE
//   - CTRL register bit positions
//   - Region-select enum used by the address decode
package bip_io_pkg;

  localparam int unsigned OFS_PORT_OUT = 0;
  localparam int unsigned OFS_PORT_IN  = 1;
  localparam int unsigned OFS_RELOAD   = 2;
  localparam int unsigned OFS_COUNT    = 3;
  localparam int unsigned OFS_CTRL     = 4;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_FLAG_BIT = 1;

  typedef enum logic {
    REGION_RAM = 1'b0,
    REGION_IO  = 1'b1
  } region_e;

endpackage

// File: rtl/bip_timer.sv
// bip_timer: reload timer with sticky flag for the BIP2 I/O window.
// Optional feature macro: BIP_TIMER_PRESCALE_EN (adds parameter PRESCALE and
// a prescale counter; the timer then steps only when it wraps to 0).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wdata           write data from the core
//   i_wr_reload       write strobe decoded for RELOAD
//   i_wr_ctrl         write strobe decoded for CTRL
//   o_reload/o_count  RELOAD and COUNT registers
//   o_en/o_flag       CTRL.EN and CTRL.FLAG
module bip_timer
  import bip_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
`ifdef BIP_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 16
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_wr_reload,
  input  logic                  i_wr_ctrl,
  output logic [DATA_WIDTH-1:0] o_reload,
  output logic [DATA_WIDTH-1:0] o_count,
  output logic                  o_en,
  output logic                  o_flag
);

  logic [DATA_WIDTH-1:0] r_reload;
  logic [DATA_WIDTH-1:0] r_count;
  logic                  r_en;
  logic                  r_flag;
  logic                  w_step;
  logic                  w_flag_set;

`ifdef BIP_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] r_pre;
  logic          w_pre_wrap;

  always_comb begin
    w_pre_wrap = (r_pre == PW'(PRESCALE - 1));
    w_step     = r_en && w_pre_wrap;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_wr_reload) begin
      r_pre <= '0;
    end else if (r_en) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
    end
  end
`else
  always_comb begin
    w_step = r_en;
  end
`endif

  // The step decision uses the EN value from before any CTRL write this edge.
  always_comb begin
    w_flag_set = w_step && (r_count == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reload <= '0;
      r_count  <= '0;
      r_en     <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      if (i_wr_ctrl) begin
        r_en <= i_wdata[CTRL_EN_BIT];
      end
      // A set in the same edge as a write-1-to-clear keeps the flag high.
      if (w_flag_set) begin
        r_flag <= 1'b1;
      end else if (i_wr_ctrl && i_wdata[CTRL_FLAG_BIT]) begin
        r_flag <= 1'b0;
      end
      if (i_wr_reload) begin
        r_reload <= i_wdata;
        r_count  <= i_wdata;
      end else if (w_step) begin
        r_count <= (r_count == '0) ? r_reload : r_count - 1'b1;
      end
    end
  end

  assign o_reload = r_reload;
  assign o_count  = r_count;
  assign o_en     = r_en;
  assign o_flag   = r_flag;

endmodule

// File: rtl/bip_data_responder.sv
// bip_data_responder: data-memory responder for the BIP2 core.
// Addresses below IO_BASE hit a word RAM; IO_BASE+0..+15 is the I/O window
// (PORT_OUT, PORT_IN, RELOAD, COUNT, CTRL; remaining offsets read 0).
// Reads are combinational so the single-cycle core sees data the same cycle.
// Optional feature macro: BIP_TIMER_PRESCALE_EN (timer prescaler, PRESCALE).
// Ports:
//   clock_in, reset_in   clock, synchronous active-high reset
//   data_address_in      word address from the core
//   data_in, data_wr_in  write data and write strobe
//   data_out             combinational read data
//   port_in              asynchronous input pins (2-flop synchronized)
//   port_out             registered output port
//   timer_flag_out       level copy of CTRL.FLAG
module bip_data_responder
  import bip_io_pkg::*;
#(
  parameter int unsigned             ADDRESS_WIDTH = 11,
  parameter int unsigned             DATA_WIDTH    = 16,
  parameter logic [ADDRESS_WIDTH-1:0] IO_BASE      = 11'h7F0
`ifdef BIP_TIMER_PRESCALE_EN
  ,
  parameter int unsigned             PRESCALE      = 16
`endif
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [ADDRESS_WIDTH-1:0] data_address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_wr_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic [DATA_WIDTH-1:0]    port_in,
  output logic [DATA_WIDTH-1:0]    port_out,
  output logic                     timer_flag_out
);

  logic [DATA_WIDTH-1:0]    r_ram [IO_BASE];
  logic [DATA_WIDTH-1:0]    r_port_out;
  logic [DATA_WIDTH-1:0]    r_sync1;
  logic [DATA_WIDTH-1:0]    r_sync2;

  region_e                  w_region;
  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic                     w_wr_ram;
  logic                     w_wr_port;
  logic                     w_wr_reload;
  logic                     w_wr_ctrl;
  logic [DATA_WIDTH-1:0]    w_reload;
  logic [DATA_WIDTH-1:0]    w_count;
  logic                     w_en;
  logic                     w_flag;

  always_comb begin
    w_region    = (data_address_in < IO_BASE) ? REGION_RAM : REGION_IO;
    w_offset    = data_address_in - IO_BASE;
    w_wr_ram    = data_wr_in && (w_region == REGION_RAM) && !reset_in;
    w_wr_port   = 1'b0;
    w_wr_reload = 1'b0;
    w_wr_ctrl   = 1'b0;
    if (data_wr_in && (w_region == REGION_IO)) begin
      w_wr_port   = (w_offset == ADDRESS_WIDTH'(OFS_PORT_OUT));
      w_wr_reload = (w_offset == ADDRESS_WIDTH'(OFS_RELOAD));
      w_wr_ctrl   = (w_offset == ADDRESS_WIDTH'(OFS_CTRL));
    end
  end

  // RAM has no reset; writes are blocked while reset is asserted.
  always_ff @(posedge clock_in) begin
    if (w_wr_ram) begin
      r_ram[data_address_in] <= data_in;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_port_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
    end else begin
      if (w_wr_port) begin
        r_port_out <= data_in;
      end
      r_sync1 <= port_in;
      r_sync2 <= r_sync1;
    end
  end

  bip_timer #(
    .DATA_WIDTH(DATA_WIDTH)
`ifdef BIP_TIMER_PRESCALE_EN
    ,
    .PRESCALE  (PRESCALE)
`endif
  ) u_timer (
    .i_clk      (clock_in),
    .i_rst      (reset_in),
    .i_wdata    (data_in),
    .i_wr_reload(w_wr_reload),
    .i_wr_ctrl  (w_wr_ctrl),
    .o_reload   (w_reload),
    .o_count    (w_count),
    .o_en       (w_en),
    .o_flag     (w_flag)
  );

  always_comb begin
    data_out = '0;
    if (w_region == REGION_RAM) begin
      data_out = r_ram[data_address_in];
    end else begin
      case (w_offset)
        ADDRESS_WIDTH'(OFS_PORT_OUT): data_out = r_port_out;
        ADDRESS_WIDTH'(OFS_PORT_IN):  data_out = r_sync2;
        ADDRESS_WIDTH'(OFS_RELOAD):   data_out = w_reload;
        ADDRESS_WIDTH'(OFS_COUNT):    data_out = w_count;
        ADDRESS_WIDTH'(OFS_CTRL): begin
          data_out[CTRL_EN_BIT]   = w_en;
          data_out[CTRL_FLAG_BIT] = w_flag;
        end
        default: data_out = '0;
      endcase
    end
  end

  assign port_out       = r_port_out;
  assign timer_flag_out = w_flag;

endmodule

// File: tb/tb_bip_data_responder.sv
// Testbench for bip_data_responder (default build, no prescaler).
module tb_bip_data_responder;

  localparam logic [10:0] IOB = 11'h7F0;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] addr;
  logic [15:0] din;
  logic        wr;
  logic [15:0] dout;
  logic [15:0] pin;
  logic [15:0] pout;
  logic        tflag;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state described as the register map, not the hardware.
  logic [15:0] m_ram   [2048];
  bit          m_valid [2048];
  logic [15:0] m_port_out, m_reload, m_count;
  logic [15:0] m_pin_hist [2];   // pin value seen at the last two edges
  bit          m_en, m_flag;

  bip_data_responder #(
    .ADDRESS_WIDTH(11),
    .DATA_WIDTH   (16),
    .IO_BASE      (11'h7F0)
  ) dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .data_address_in(addr),
    .data_in        (din),
    .data_wr_in     (wr),
    .data_out       (dout),
    .port_in        (pin),
    .port_out       (pout),
    .timer_flag_out (tflag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit read_known(input logic [10:0] a);
    return (a >= IOB) || m_valid[a];
  endfunction

  function automatic logic [15:0] model_read(input logic [10:0] a);
    int unsigned off;
    if (a < IOB) return m_ram[a];
    off = int'(a) - int'(IOB);
    case (off)
      0: return m_port_out;
      1: return m_pin_hist[1];
      2: return m_reload;
      3: return m_count;
      4: return {14'd0, m_flag, m_en};
      default: return 16'h0000;
    endcase
  endfunction

  // Apply the rules of one rising edge to the reference state.
  task automatic model_edge(input logic r, input logic [10:0] a, input logic [15:0] d,
                            input logic w, input logic [15:0] p);
    bit          io, timer_fires;
    int unsigned off;
    logic [15:0] next_count;
    if (r) begin
      m_port_out = 0; m_reload = 0; m_count = 0; m_en = 0; m_flag = 0;
      m_pin_hist[0] = 0; m_pin_hist[1] = 0;
      return;
    end
    io  = (a >= IOB);
    off = io ? int'(a) - int'(IOB) : 0;
    timer_fires = m_en && (m_count == 0);
    next_count  = m_count;
    if (m_en) next_count = (m_count == 0) ? m_reload : m_count - 16'd1;
    if (w && io && off == 2) begin
      m_reload   = d;
      next_count = d;
    end
    m_count = next_count;
    if (timer_fires) m_flag = 1;
    else if (w && io && off == 4 && d[1]) m_flag = 0;
    if (w && io && off == 4) m_en = d[0];
    if (w && io && off == 0) m_port_out = d;
    if (w && !io) begin
      m_ram[a]   = d;
      m_valid[a] = 1;
    end
    m_pin_hist[1] = m_pin_hist[0];
    m_pin_hist[0] = p;
  endtask

  // Called just after a falling edge; checks the read before and outputs after the edge.
  task automatic tick(input logic r, input logic [10:0] a, input logic [15:0] d,
                      input logic w, input logic [15:0] p);
    rst = r; addr = a; din = d; wr = w; pin = p;
    #1;
    if (read_known(a)) chk("read_pre_edge", dout, model_read(a));
    @(posedge clk);
    model_edge(r, a, d, w, p);
    #1;
    chk("port_out", pout, m_port_out);
    chk("timer_flag_out", {15'd0, tflag}, {15'd0, m_flag});
    @(negedge clk);
  endtask

  // Idle read with a constant expectation from the directed plan.
  task automatic look(input string tag, input logic [10:0] a, input logic [15:0] exp);
    wr = 0; rst = 0; addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    logic [10:0] ra;
    logic [15:0] rd;
    logic        rw, rr;
    for (int i = 0; i < 2048; i++) m_valid[i] = 0;
    rst = 1; addr = 0; din = 0; wr = 0; pin = 0;
    @(negedge clk);
    tick(1, 11'h000, 16'h0000, 0, 16'h0000);
    tick(1, 11'h000, 16'h0000, 0, 16'h0000);
    look("reset_port_out", IOB + 11'd0, 16'h0000);
    look("reset_count", IOB + 11'd3, 16'h0000);
    look("reset_ctrl", IOB + 11'd4, 16'h0000);

    // RAM
    tick(0, 11'd6, 16'h5555, 1, 16'h0000);
    tick(0, 11'd5, 16'h1234, 1, 16'h0000);
    look("ram_5", 11'd5, 16'h1234);
    tick(0, 11'd6, 16'h7777, 1, 16'h0000);
    look("ram_6_new", 11'd6, 16'h7777);

    // I/O window
    tick(0, IOB + 11'd0, 16'hA5A5, 1, 16'h0000);
    chk("port_out_a5a5", pout, 16'hA5A5);
    tick(0, IOB + 11'd1, 16'hFFFF, 1, 16'h0000);
    look("port_in_ro", IOB + 11'd1, 16'h0000);
    tick(0, IOB + 11'd8, 16'hFFFF, 1, 16'h0000);
    look("unmapped_8", IOB + 11'd8, 16'h0000);

    // Synchronizer
    tick(0, IOB + 11'd1, 16'h0000, 0, 16'h00FF);
    look("sync_1edge", IOB + 11'd1, 16'h0000);
    tick(0, IOB + 11'd1, 16'h0000, 0, 16'h00FF);
    look("sync_2edge", IOB + 11'd1, 16'h00FF);

    // Timer 3,2,1,0,3
    tick(0, IOB + 11'd2, 16'd3, 1, 16'h00FF);
    tick(0, IOB + 11'd4, 16'h0001, 1, 16'h00FF);
    look("count_3", IOB + 11'd3, 16'd3);
    for (int k = 0; k < 4; k++) tick(0, IOB + 11'd3, 16'h0000, 0, 16'h00FF);
    look("count_reload", IOB + 11'd3, 16'd3);
    chk("flag_set", {15'd0, tflag}, 16'd1);
    tick(0, IOB + 11'd4, 16'h0003, 1, 16'h00FF);
    look("ctrl_clear", IOB + 11'd4, 16'h0001);

    // Flag race: RELOAD=0, EN=1, then CTRL=2
    tick(0, IOB + 11'd2, 16'd0, 1, 16'h00FF);
    tick(0, IOB + 11'd3, 16'd0, 0, 16'h00FF);
    tick(0, IOB + 11'd4, 16'h0002, 1, 16'h00FF);
    look("race_set_wins", IOB + 11'd4, 16'h0002);
    tick(0, IOB + 11'd3, 16'd0, 0, 16'h00FF);
    look("race_hold", IOB + 11'd4, 16'h0002);

    // Reset mid-count
    tick(0, IOB + 11'd2, 16'd2, 1, 16'h00FF);
    tick(0, IOB + 11'd4, 16'h0001, 1, 16'h00FF);
    tick(1, IOB + 11'd2, 16'd9, 1, 16'h00FF);
    look("rst_count", IOB + 11'd3, 16'h0000);
    look("rst_ctrl", IOB + 11'd4, 16'h0000);
    chk("rst_port_out", pout, 16'h0000);
    look("rst_ram_kept", 11'd5, 16'h1234);

    // Randomized traffic against the reference state
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) < 3) ra = 11'($urandom_range(0, 15));
      else ra = IOB + 11'($urandom_range(0, 15));
      rw = ($urandom_range(0, 2) != 0);
      rd = 16'($urandom);
      if (ra == IOB + 11'd2) rd = 16'($urandom_range(0, 5));
      if (ra == IOB + 11'd4) rd = 16'($urandom_range(0, 3));
      rr = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pin = 16'($urandom);
      tick(rr, ra, rd, rw, pin);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
